// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative MixColumns stage for an NB-column Rijndael
// state. It transforms COLS_PER_CYCLE columns per clock behind a
// valid/ready handshake, and supports forward mode and bypass.
//
// Optional feature macro: INV_MIX_COLUMNS_EN. When it is defined, inv=1
// selects InvMixColumns. When it is not defined, inv is ignored, no inverse
// multiplier logic is built, and the inv port is still present.
//
// Handshake: a state is accepted on a rising edge where in_valid && in_ready.
// The producer holds in_data/enable/inv stable until that edge. A result is
// handed off on a rising edge where out_valid && out_ready. out_valid and
// out_data stay stable until that edge.
module mix_columns_iter #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              enable,
    input  logic              inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data
);

    // Reject illegal configurations at elaboration time
    if (NB < 4 || NB > 8) begin : g_bad_nb
        $error("mix_columns_iter: NB must be in 4..8");
    end
    if (COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cpc
        $error("mix_columns_iter: COLS_PER_CYCLE must divide NB");
    end

    localparam int CIW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CIW-1:0]     col_idx_q, col_idx_d;
    logic [32*NB-1:0]   work_q, work_d;
    logic [32*NB-1:0]   out_q, out_d;
    logic               en_q, en_d;
    logic [32*NB-1:0]   work_xf;
    logic [31:0]        col_in, col_out;
    logic               accept;
    logic               last_group;
    int                 col_base;

`ifdef INV_MIX_COLUMNS_EN
    logic               inv_q, inv_d;
`else
    // inv has no effect in a forward-only build
    logic               unused_inv;
    assign unused_inv = inv;
`endif

    // GF(2^8) multiply by 2, reduction polynomial 0x11B
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns on one column; byte 0 is the MSB byte
    function automatic logic [31:0] fwd_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
        b3 = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        return {b0, b1, b2, b3};
    endfunction

`ifdef INV_MIX_COLUMNS_EN
    // Multiples 9, B, D, E built from x*2, x*4, x*8
    function automatic logic [7:0] m9(input logic [7:0] x);
        return xt(xt(xt(x))) ^ x;
    endfunction
    function automatic logic [7:0] mb(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(x) ^ x;
    endfunction
    function automatic logic [7:0] md(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
    endfunction
    function automatic logic [7:0] me(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
    endfunction

    // InvMixColumns on one column
    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
        b1 = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
        b2 = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
        b3 = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
        return {b0, b1, b2, b3};
    endfunction
`endif

    assign col_base   = int'(col_idx_q);
    assign last_group = (col_base + COLS_PER_CYCLE) == NB;
    assign in_ready   = !rst && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && out_ready));
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == ST_DONE);
    assign out_data   = out_q;

    // Working register with the current column group transformed in place
    always_comb begin
        work_xf = work_q;
        col_in  = '0;
        col_out = '0;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_in = work_q[32*(col_base+g) +: 32];
`ifdef INV_MIX_COLUMNS_EN
            if (!en_q)
                col_out = col_in;
            else if (inv_q)
                col_out = inv_col(col_in);
            else
                col_out = fwd_col(col_in);
`else
            col_out = en_q ? fwd_col(col_in) : col_in;
`endif
            work_xf[32*(col_base+g) +: 32] = col_out;
        end
    end

    // Next-state logic for the IDLE/BUSY/DONE controller and datapath
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        work_d    = work_q;
        out_d     = out_q;
        en_d      = en_q;
`ifdef INV_MIX_COLUMNS_EN
        inv_d     = inv_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d   = ST_BUSY;
                    col_idx_d = '0;
                    work_d    = in_data;
                    en_d      = enable;
`ifdef INV_MIX_COLUMNS_EN
                    inv_d     = inv;
`endif
                end else if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                work_d = work_xf;
                if (last_group) begin
                    state_d   = ST_DONE;
                    col_idx_d = '0;
                    out_d     = work_xf;
                end else begin
                    col_idx_d = col_idx_q + CIW'(COLS_PER_CYCLE);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                col_idx_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_idx_q <= '0;
            work_q    <= '0;
            out_q     <= '0;
            en_q      <= 1'b0;
`ifdef INV_MIX_COLUMNS_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            work_q    <= work_d;
            out_q     <= out_d;
            en_q      <= en_d;
`ifdef INV_MIX_COLUMNS_EN
            inv_q     <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed bench for mix_columns_iter. Main instance
// uses the defaults; extra instances cover COLS_PER_CYCLE=2/4 and NB=8.
module tb_mix_columns_iter;

    localparam logic [127:0] V1 = 128'hc6c6c6c6_01010101_f20a225c_db135345;
    localparam logic [127:0] E1 = 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc;
    localparam logic [127:0] D4 = {4{32'hd4d4d4d5}};
    localparam logic [127:0] D5 = {4{32'hd5d5d7d6}};
    localparam logic [255:0] N8_IN  = {8{32'h2d26314c}};
    localparam logic [255:0] N8_OUT = {8{32'h4d7ebdf8}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_valid_c2, in_valid_c4, in_valid8;
    logic [127:0] in_data;
    logic [255:0] in_data8;
    logic         enable, inv, out_ready;
    logic         in_ready, in_ready_c2, in_ready_c4, in_ready8;
    logic         out_valid, out_valid_c2, out_valid_c4, out_valid8;
    logic [127:0] out_data, out_data_c2, out_data_c4;
    logic [255:0] out_data8;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    // Clock and watchdog
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    mix_columns_iter #(.NB(4), .COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .enable(enable), .inv(inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

    mix_columns_iter #(.NB(4), .COLS_PER_CYCLE(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_c2), .in_ready(in_ready_c2),
        .in_data(in_data), .enable(enable), .inv(inv),
        .out_valid(out_valid_c2), .out_ready(out_ready), .out_data(out_data_c2));

    mix_columns_iter #(.NB(4), .COLS_PER_CYCLE(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_c4), .in_ready(in_ready_c4),
        .in_data(in_data), .enable(enable), .inv(inv),
        .out_valid(out_valid_c4), .out_ready(out_ready), .out_data(out_data_c4));

    mix_columns_iter #(.NB(8), .COLS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .enable(enable), .inv(inv),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8));

    // Reference model: generic shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_model(input logic [31:0] c, input logic iv);
        logic [7:0] a [4];
        logic [7:0] m [4];
        logic [7:0] b;
        logic [31:0] r = '0;
        for (int j = 0; j < 4; j++) a[j] = c[31-8*j -: 8];
        if (iv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int i = 0; i < 4; i++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], m[(j - i + 4) % 4]);
            r[31-8*i -: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [127:0] state_model(input logic [127:0] d, input logic en,
                                                 input logic iv);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            r[32*c +: 32] = en ? mix_model(d[32*c +: 32], iv) : d[32*c +: 32];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one state into the main instance and push its expected result
    task automatic send(input logic [127:0] d, input logic en, input logic iv,
                        input logic [127:0] exp);
        int n = 0;
        in_data  = d;
        enable   = en;
        inv      = iv;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_in_ready", 256'(in_ready), 256'(1'b1));
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        enable   = 1'($urandom_range(0, 1));
        inv      = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Wait for a result, check latency and data, hand off if out_ready
    task automatic expect_out(input string tag, input int lat);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 256'(n), 256'(lat));
        check({tag, "_out_valid"}, 256'(out_valid), 256'(1'b1));
        if (exp_q.size() == 0)
            check({tag, "_queue_empty"}, 256'(0), 256'(1));
        else
            check({tag, "_out_data"}, 256'(out_data), 256'(exp_q.pop_front()));
        if (out_ready) tick();
    endtask

    initial begin
        logic [127:0] d, exp;
        logic en;
        int n;
        rst = 1'b1;
        in_valid = 1'b0; in_valid_c2 = 1'b0; in_valid_c4 = 1'b0; in_valid8 = 1'b0;
        in_data = '0; in_data8 = '0; enable = 1'b0; inv = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_in_ready", 256'(in_ready), 256'(1'b0));
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_out_data", 256'(out_data), 256'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 256'(in_ready), 256'(1'b1));

        // Forward transform
        send(V1, 1'b1, 1'b0, E1);
        expect_out("fwd", 4);

        // Bypass, with in_valid ignored while busy
        send(V1, 1'b0, 1'b0, V1);
        in_valid = 1'b1; in_data = D4; enable = 1'b1;
        #1;
        check("busy_in_ready", 256'(in_ready), 256'(1'b0));
        tick();
        tick();
        in_valid = 1'b0;
        expect_out("bypass", 2);

        // inv=1: inverse when the feature is built, forward otherwise
`ifdef INV_MIX_COLUMNS_EN
        exp = V1;
`else
        exp = state_model(E1, 1'b1, 1'b0);
`endif
        send(E1, 1'b1, 1'b1, exp);
        expect_out("inv", 4);

        // Backpressure in DONE, then back-to-back accept
        out_ready = 1'b0;
        send(V1, 1'b1, 1'b0, E1);
        expect_out("bp_first", 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 256'(out_valid), 256'(1'b1));
            check("bp_out_data", 256'(out_data), 256'(E1));
            check("bp_in_ready", 256'(in_ready), 256'(1'b0));
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = D4; enable = 1'b1; inv = 1'b0;
        #1;
        check("b2b_in_ready", 256'(in_ready), 256'(1'b1));
        exp_q.push_back(D5);
        tick();
        in_valid = 1'b0;
        check("b2b_valid_drop", 256'(out_valid), 256'(1'b0));
        check("b2b_data_kept", 256'(out_data), 256'(E1));
        expect_out("b2b", 4);

        // Reset during the second busy cycle discards the state
        send(V1, 1'b1, 1'b0, E1);
        void'(exp_q.pop_back());
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(1'b0));
        check("midrst_out_data", 256'(out_data), 256'(0));
        check("midrst_in_ready", 256'(in_ready), 256'(1'b1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_output", 256'(out_valid), 256'(1'b0));
        end
        send(V1, 1'b1, 1'b0, E1);
        expect_out("post_midrst", 4);

        // Random states against the reference model
        for (int i = 0; i < 4; i++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            en = 1'($urandom_range(0, 1));
            send(d, en, 1'b0, state_model(d, en, 1'b0));
            expect_out("rand", 4);
        end

        // COLS_PER_CYCLE = 2
        in_data = V1; enable = 1'b1; inv = 1'b0; in_valid_c2 = 1'b1;
        #1;
        check("c2_in_ready", 256'(in_ready_c2), 256'(1'b1));
        tick();
        in_valid_c2 = 1'b0;
        n = 0;
        while (!out_valid_c2 && n < 20) begin tick(); n++; end
        check("c2_latency", 256'(n), 256'(2));
        check("c2_out_data", 256'(out_data_c2), 256'(E1));
        tick();

        // COLS_PER_CYCLE = 4
        in_data = V1; enable = 1'b1; inv = 1'b0; in_valid_c4 = 1'b1;
        #1;
        check("c4_in_ready", 256'(in_ready_c4), 256'(1'b1));
        tick();
        in_valid_c4 = 1'b0;
        n = 0;
        while (!out_valid_c4 && n < 20) begin tick(); n++; end
        check("c4_latency", 256'(n), 256'(1));
        check("c4_out_data", 256'(out_data_c4), 256'(E1));
        tick();

        // NB = 8
        in_data8 = N8_IN; enable = 1'b1; inv = 1'b0; in_valid8 = 1'b1;
        #1;
        check("nb8_in_ready", 256'(in_ready8), 256'(1'b1));
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 20) begin tick(); n++; end
        check("nb8_latency", 256'(n), 256'(8));
        check("nb8_out_data", out_data8, N8_OUT);
        tick();

        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
